// File: rtl/accum_serial_unit.sv
// accum_serial_unit: run-once accumulator with a slice-serial adder.
// Each Run press performs one of add / subtract / load / clear on Acc.
// Add and subtract reuse one SLICE-bit adder over WIDTH/SLICE cycles.
// Optional feature macro: ACCUM_SATURATE_EN. When it is defined, an add
// that overflows clamps Acc to all ones and a subtract that borrows clamps
// Acc to zero. Carry reports the overflow or borrow in both builds.
module accum_serial_unit #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             Clk,
    input  logic             Reset_Clear,
    input  logic             Run,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Acc,
    output logic             Carry,
    output logic             Busy,
    output logic             Done
);

    localparam int NS = WIDTH / SLICE;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NS - 1);

    localparam logic [1:0] MODE_LOAD  = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    // The slice loop needs WIDTH to be an exact multiple of SLICE.
    generate
        if ((WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("accum_serial_unit: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADD  = 2'b01,
        ST_DONE = 2'b10,
        ST_WAIT = 2'b11
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              run_q_r;
    logic              start_s;

    logic [WIDTH-1:0]  acc_r;
    logic              carry_r;
    logic              busy_r;
    logic              done_r;

    // Frozen operands and serial adder state
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              c_r;
    logic              sub_r;
    logic [IW-1:0]     idx_r;
    logic [WIDTH-1:0]  res_r;

    // Control strobes from the FSM
    logic              do_load_s;
    logic              do_clear_s;
    logic              do_start_add_s;
    logic              do_step_s;
    logic              do_finish_s;

    // Slice datapath
    logic [SLICE-1:0]  slice_a_s;
    logic [SLICE-1:0]  slice_b_s;
    logic [SLICE:0]    sum_s;
    logic [WIDTH-1:0]  final_s;
    logic              carry_flag_s;
    logic [WIDTH-1:0]  acc_result_s;

    assign start_s = Run & ~run_q_r;

    // State register and Run edge-detect history
    always_ff @(posedge Clk or negedge Reset_Clear) begin
        if (!Reset_Clear) begin
            state_r <= ST_IDLE;
            run_q_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            run_q_r <= Run;
        end
    end

    // Next-state logic and per-state datapath strobes
    always_comb begin
        state_next_s   = state_r;
        do_load_s      = 1'b0;
        do_clear_s     = 1'b0;
        do_start_add_s = 1'b0;
        do_step_s      = 1'b0;
        do_finish_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    case (Mode)
                        MODE_LOAD: begin
                            do_load_s    = 1'b1;
                            state_next_s = ST_DONE;
                        end
                        MODE_CLEAR: begin
                            do_clear_s   = 1'b1;
                            state_next_s = ST_DONE;
                        end
                        default: begin
                            do_start_add_s = 1'b1;
                            state_next_s   = ST_ADD;
                        end
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ADD: begin
                do_step_s = 1'b1;
                if (idx_r == LAST_IDX) begin
                    do_finish_s  = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ADD;
                end
            end
            ST_DONE: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (!Run) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Select the operand slices addressed by the slice index
    always_comb begin
        slice_a_s = '0;
        slice_b_s = '0;
        for (int k = 0; k < NS; k++) begin
            if (idx_r == IW'(k)) begin
                slice_a_s = a_r[k*SLICE +: SLICE];
                slice_b_s = b_r[k*SLICE +: SLICE];
            end else begin
                slice_a_s = slice_a_s;
                slice_b_s = slice_b_s;
            end
        end
    end

    assign sum_s = {1'b0, slice_a_s} + {1'b0, slice_b_s} + {{SLICE{1'b0}}, c_r};

    // Assemble the full result; the top slice comes straight from the adder
    always_comb begin
        final_s = res_r;
        final_s[(NS-1)*SLICE +: SLICE] = sum_s[SLICE-1:0];
        // For subtract, a missing carry-out means the result wrapped below 0.
        carry_flag_s = sub_r ? ~sum_s[SLICE] : sum_s[SLICE];
`ifdef ACCUM_SATURATE_EN
        if (carry_flag_s) begin
            acc_result_s = sub_r ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
        end else begin
            acc_result_s = final_s;
        end
`else
        acc_result_s = final_s;
`endif
    end

    // Serial adder operands, running carry, slice index and partial result
    always_ff @(posedge Clk or negedge Reset_Clear) begin
        if (!Reset_Clear) begin
            a_r   <= '0;
            b_r   <= '0;
            c_r   <= 1'b0;
            sub_r <= 1'b0;
            idx_r <= '0;
            res_r <= '0;
        end else if (do_start_add_s) begin
            // Subtract is Acc + ~Din + 1: invert Din and seed the carry.
            a_r   <= Mode[0] ? ~Din : Din;
            b_r   <= acc_r;
            c_r   <= Mode[0];
            sub_r <= Mode[0];
            idx_r <= '0;
            res_r <= '0;
        end else if (do_step_s) begin
            c_r   <= sum_s[SLICE];
            idx_r <= idx_r + IW'(1);
            for (int k = 0; k < NS; k++) begin
                if (idx_r == IW'(k)) begin
                    res_r[k*SLICE +: SLICE] <= sum_s[SLICE-1:0];
                end
            end
        end
    end

    // Architectural accumulator and carry/borrow flag
    always_ff @(posedge Clk or negedge Reset_Clear) begin
        if (!Reset_Clear) begin
            acc_r   <= '0;
            carry_r <= 1'b0;
        end else if (do_load_s) begin
            acc_r   <= Din;
            carry_r <= 1'b0;
        end else if (do_clear_s) begin
            acc_r   <= '0;
            carry_r <= 1'b0;
        end else if (do_finish_s) begin
            acc_r   <= acc_result_s;
            carry_r <= carry_flag_s;
        end
    end

    // Registered status: Busy tracks ADD, Done marks the single DONE cycle
    always_ff @(posedge Clk or negedge Reset_Clear) begin
        if (!Reset_Clear) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ST_ADD);
            done_r <= (state_next_s == ST_DONE);
        end
    end

    assign Acc   = acc_r;
    assign Carry = carry_r;
    assign Busy  = busy_r;
    assign Done  = done_r;

endmodule

// File: tb/tb_accum_serial_unit.sv
// Directed bench for accum_serial_unit (WIDTH=16, SLICE=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_accum_serial_unit;

    localparam int WIDTH = 16;
    localparam int SLICE = 4;
    localparam int NS    = WIDTH / SLICE;

    logic             Clk;
    logic             Reset_Clear;
    logic             Run;
    logic [1:0]       Mode;
    logic [WIDTH-1:0] Din;
    logic [WIDTH-1:0] Acc;
    logic             Carry;
    logic             Busy;
    logic             Done;

    int n_vec = 0;
    int n_err = 0;
    logic [WIDTH-1:0] model_acc;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] din;
        logic [15:0] acc;
        logic        carry;
    } vec_t;

    vec_t vecs[12];

    accum_serial_unit #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .Clk         (Clk),
        .Reset_Clear (Reset_Clear),
        .Run         (Run),
        .Mode        (Mode),
        .Din         (Din),
        .Acc         (Acc),
        .Carry       (Carry),
        .Busy        (Busy),
        .Done        (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Hard stop in case something never completes
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One Run press from IDLE; called on a falling edge, returns on one.
    task automatic do_op(input logic [1:0] m, input logic [15:0] d,
                         input logic [15:0] e_acc, input logic e_carry,
                         input string tag);
        int cyc;
        int busy_n;
        bit seen;
        cyc    = 0;
        busy_n = 0;
        seen   = 1'b0;
        Mode   = m;
        Din    = d;
        Run    = 1'b1;
        while (!seen && cyc < 20) begin
            @(negedge Clk);
            cyc++;
            if (Busy) busy_n++;
            if (Done) seen = 1'b1;
            else chk({tag, "_acc_hold"}, 32'(Acc), 32'(model_acc));
        end
        chk({tag, "_latency"}, cyc, m[1] ? 1 : NS + 1);
        chk({tag, "_busy_cycles"}, busy_n, m[1] ? 0 : NS);
        chk({tag, "_acc"}, 32'(Acc), 32'(e_acc));
        chk({tag, "_carry"}, 32'(Carry), 32'(e_carry));
        @(negedge Clk);
        chk({tag, "_done_single"}, 32'(Done), 32'd0);
        Run = 1'b0;
        @(negedge Clk);
        model_acc = e_acc;
    endtask

    initial begin
        int done_n;

        vecs[0]  = '{2'b10, 16'h1234, 16'h1234, 1'b0};
        vecs[1]  = '{2'b00, 16'h0001, 16'h1235, 1'b0};
        vecs[2]  = '{2'b10, 16'hFFFF, 16'hFFFF, 1'b0};
`ifdef ACCUM_SATURATE_EN
        vecs[3]  = '{2'b00, 16'h0002, 16'hFFFF, 1'b1};
`else
        vecs[3]  = '{2'b00, 16'h0002, 16'h0001, 1'b1};
`endif
        vecs[4]  = '{2'b11, 16'hBEEF, 16'h0000, 1'b0};
        vecs[5]  = '{2'b10, 16'h0005, 16'h0005, 1'b0};
`ifdef ACCUM_SATURATE_EN
        vecs[6]  = '{2'b01, 16'h0007, 16'h0000, 1'b1};
`else
        vecs[6]  = '{2'b01, 16'h0007, 16'hFFFE, 1'b1};
`endif
        vecs[7]  = '{2'b10, 16'h0005, 16'h0005, 1'b0};
        vecs[8]  = '{2'b01, 16'h0005, 16'h0000, 1'b0};
        vecs[9]  = '{2'b10, 16'hA5A5, 16'hA5A5, 1'b0};
        vecs[10] = '{2'b00, 16'h0F0F, 16'hB4B4, 1'b0};
        vecs[11] = '{2'b01, 16'h1111, 16'hA3A3, 1'b0};

        // Reset held with Run toggling: everything stays cleared
        Reset_Clear = 1'b0;
        Run         = 1'b0;
        Mode        = 2'b00;
        Din         = 16'h0000;
        model_acc   = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            Run = ~Run;
            chk("rst_acc", 32'(Acc), 32'd0);
            chk("rst_carry", 32'(Carry), 32'd0);
            chk("rst_busy", 32'(Busy), 32'd0);
            chk("rst_done", 32'(Done), 32'd0);
        end
        Run = 1'b0;
        @(negedge Clk);
        Reset_Clear = 1'b1;
        @(negedge Clk);

        // Table of single operations
        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].mode, vecs[i].din, vecs[i].acc, vecs[i].carry,
                  $sformatf("vec%0d", i));
        end

        // Held Run with Din/Mode changes during and after ADD
        do_op(2'b11, 16'h0000, 16'h0000, 1'b0, "pre_hold_clear");
        Mode   = 2'b00;
        Din    = 16'h0003;
        Run    = 1'b1;
        done_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (i == 1) Din = 16'h0100;
            if (i == 10) Mode = 2'b10;
            if (Done) done_n++;
        end
        chk("hold_done_count", done_n, 1);
        chk("hold_acc", 32'(Acc), 32'h0003);
        chk("hold_carry", 32'(Carry), 32'd0);
        Run = 1'b0;
        @(negedge Clk);
        model_acc = 16'h0003;
        do_op(2'b00, 16'h0100, 16'h0103, 1'b0, "repress");

        // Reset during the second ADD cycle
        Mode = 2'b00;
        Din  = 16'h0001;
        Run  = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        chk("midrst_busy_before", 32'(Busy), 32'd1);
        Reset_Clear = 1'b0;
        #1;
        chk("midrst_acc", 32'(Acc), 32'd0);
        chk("midrst_busy", 32'(Busy), 32'd0);
        chk("midrst_done", 32'(Done), 32'd0);
        chk("midrst_carry", 32'(Carry), 32'd0);
        Run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("midrst_no_done", 32'(Done), 32'd0);
        end
        Reset_Clear = 1'b1;
        @(negedge Clk);
        model_acc = 16'h0000;
        do_op(2'b00, 16'h0007, 16'h0007, 1'b0, "post_rst_add");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/accum_serial_unit.md
Name: accum_serial_unit

Overview:
- Parametrised accumulator engine for the adders lab datapath; next generation of the switch-to-register accumulator.
- Adds or subtracts the input operand into the accumulator, and can also load or clear it.
- The adder is slice-serial: SLICE bits per clock over WIDTH/SLICE cycles, reusing one narrow adder.
- Runs once per Run press through an edge-detect FSM, and reports carry/borrow, busy and done.

Parameters:
- WIDTH, 16: accumulator and operand width in bits.
- SLICE, 4: bits added per clock. WIDTH % SLICE must be 0, otherwise elaboration fails. NS = WIDTH/SLICE.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_Clear  in  1  asynchronous, active-low reset.
- Run  in  1  active-high, synchronous request (already debounced/inverted upstream).
- Mode  in  2  00 add, 01 subtract, 10 load Din, 11 clear.
- Din  in  WIDTH  operand (switch value, zero-extended upstream).
- Acc  out  WIDTH  accumulator value.
- Carry  out  1  add: carry-out of last op; sub: borrow (1 = result wrapped below 0).
- Busy  out  1  high while in ADD.
- Done  out  1  one-cycle pulse after Acc updates.

Behaviour:
- Reset (Reset_Clear=0, async): Acc=0, Carry=0, Busy=0, Done=0, state IDLE, run_q=0. Takes effect immediately, including mid-operation; partial sums are discarded.
- run_q registers Run every cycle. start = Run & ~run_q, evaluated only in IDLE.
- States:
  - IDLE: on start, sample Mode and Din.
    - Mode 10: Acc<=Din, Carry<=0, go to DONE.
    - Mode 11: Acc<=0, Carry<=0, go to DONE.
    - Mode 00/01: A<=Din (inverted for sub), B<=Acc, c<=Mode[0], idx<=0, go to ADD.
  - ADD: each cycle, sum slice idx of A+B+c into a partial-result register, c<=slice carry, idx++. After the cycle with idx=NS-1: Acc<=result, Carry<=(sub ? ~c : c), go to DONE. Acc does not change during ADD.
  - DONE: Done=1 for exactly this cycle, then go to WAIT.
  - WAIT: stay until Run=0, then go to IDLE.
- Latency:
  - start sampled at edge t0. Add/sub: Acc valid after edge t0+NS; Done high during cycle t0+NS to t0+NS+1.
  - Load/clear: Acc valid after t0; Done in the next cycle.
- One operation per press. Holding Run never retriggers. Run edges, Mode changes and Din changes outside IDLE are ignored. Operands are frozen at start.
- Arithmetic is unsigned modulo 2^WIDTH. Sub computes Acc - Din as Acc + ~Din + 1.
- Carry holds its value until the next add/sub/load/clear or reset.
- Busy=1 only in ADD.

Optional Feature:
- Macro ACCUM_SATURATE_EN.
- Defined:
  - Add with carry-out=1: Acc<=all ones.
  - Sub with borrow=1: Acc<=0.
  - Carry still reports the overflow/borrow.
- Undefined: results wrap modulo 2^WIDTH. No saturation logic is generated.

Test Plan (WIDTH=16, SLICE=4, NS=4):
- Hold Reset_Clear=0 with Run toggling, then release → Acc=0x0000, Carry=0, Busy=0, Done=0 throughout reset.
- Load 0x1234, then add Din=0x0001 → Acc=0x1235 exactly 4 clocks after the start edge, Busy high for 4 cycles, one Done pulse, Carry=0.
- Acc=0xFFFF, add 0x0002 → Acc=0x0001, Carry=1. With ACCUM_SATURATE_EN → Acc=0xFFFF, Carry=1.
- Acc=0x0005, sub 0x0007 → Acc=0xFFFE, Carry=1. Sub 0x0005 from 0x0005 → Acc=0x0000, Carry=0. With ACCUM_SATURATE_EN, first case → Acc=0x0000.
- Acc=0, hold Run=1 for 20 cycles, add 0x0003, and change Din to 0x0100 during ADD → Acc=0x0003 after exactly one operation. Release and re-press → Acc=0x0103.
- Drop Reset_Clear to 0 during the 2nd ADD cycle → Acc=0, Busy=0 that same cycle, no Done pulse. After release, the FSM is in IDLE and the next Run press works normally.
